// File: rtl/tile_plane_serializer_pkg.sv
// tile_plane_serializer_pkg: shared video-pipeline constants and pixel/tile types.
package tile_plane_serializer_pkg;
  localparam int TILE_W = 8;
  localparam int BPP = 4;
  typedef struct packed {
    logic [BPP-1:0] pal;
    logic [BPP-1:0] dot;
  } pix_t;
  typedef pix_t [TILE_W-1:0] tile_t;
endpackage

// File: rtl/tile_row_flip.sv
// tile_row_flip: attaches the palette to a GFX ROM row and applies the horizontal flip.
module tile_row_flip
  import tile_plane_serializer_pkg::*;
(
  input  logic [31:0] ROM_D,
  input  logic [7:0]  COL,
  input  logic        FLIP,
  output tile_t       ROW
);
  logic h;
  logic col_unused;
  assign h = COL[0] ^ FLIP;
  assign col_unused = ^COL[3:1];
  always_comb begin
    for (int n = 0; n < TILE_W; n++)
      ROW[n] = '{pal: COL[7:4], dot: h ? ROM_D[BPP*(TILE_W-1-n) +: BPP] : ROM_D[BPP*n +: BPP]};
  end
endmodule

// File: rtl/tile_plane_serializer.sv
// tile_plane_serializer: two-tile window (CUR/NXT) read at PCNT+ZH, one registered pixel per PIX_EN.
module tile_plane_serializer
  import tile_plane_serializer_pkg::*;
(
  input  logic        clk_24M,
  input  logic        nRES,
  input  logic        PIX_EN,
  input  logic        LOAD,
  input  logic [31:0] ROM_D,
  input  logic [7:0]  COL,
  input  logic        FLIP,
  input  logic [2:0]  ZH,
  input  logic        LAYER_EN,
  output logic [3:0]  PIX_DOT,
  output logic [3:0]  PIX_PAL,
  output logic        PIX_OPAQUE
);
  tile_t row, cur_q, cur_d, nxt_q, nxt_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic [3:0] dot_q, dot_d, pal_q, pal_d, idx;
  logic opq_q, opq_d;
  pix_t sel;
  tile_row_flip u_flip (.ROM_D(ROM_D), .COL(COL), .FLIP(FLIP), .ROW(row));
  // idx 8..14 reaches into the next tile, which is how fine scroll pulls pixels early
  assign idx = {1'b0, pcnt_q} + {1'b0, ZH};
  assign sel = idx[3] ? nxt_q[idx[2:0]] : cur_q[idx[2:0]];
  always_comb begin
    cur_d = cur_q;
    nxt_d = nxt_q;
    pcnt_d = pcnt_q;
    dot_d = dot_q;
    pal_d = pal_q;
    opq_d = opq_q;
    if (PIX_EN) begin
      dot_d = LAYER_EN ? sel.dot : '0;
      pal_d = LAYER_EN ? sel.pal : '0;
      opq_d = LAYER_EN && (sel.dot != '0);
      if (LOAD) begin
        nxt_d = row;
        cur_d = nxt_q;
        pcnt_d = '0;
      end else if (pcnt_q == 3'(TILE_W - 1)) begin
        cur_d = nxt_q;
        nxt_d = '0;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + 3'd1;
      end
    end
  end
  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      cur_q <= '0;
      nxt_q <= '0;
      pcnt_q <= '0;
      dot_q <= '0;
      pal_q <= '0;
      opq_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      nxt_q <= nxt_d;
      pcnt_q <= pcnt_d;
      dot_q <= dot_d;
      pal_q <= pal_d;
      opq_q <= opq_d;
    end
  end
  assign PIX_DOT = dot_q;
  assign PIX_PAL = pal_q;
  assign PIX_OPAQUE = opq_q;
endmodule

// File: tb/tb_tile_plane_serializer.sv
// tb_tile_plane_serializer: directed pixel-stream checks with hand-computed expected dots/palettes.
module tb_tile_plane_serializer;
  logic clk_24M = 1'b0;
  logic nRES, PIX_EN, LOAD, FLIP, LAYER_EN, PIX_OPAQUE;
  logic [31:0] ROM_D;
  logic [7:0] COL;
  logic [2:0] ZH, zh_v;
  logic [3:0] PIX_DOT, PIX_PAL;
  int total = 0;
  int bad = 0;

  tile_plane_serializer dut (
    .clk_24M(clk_24M), .nRES(nRES), .PIX_EN(PIX_EN), .LOAD(LOAD), .ROM_D(ROM_D), .COL(COL),
    .FLIP(FLIP), .ZH(ZH), .LAYER_EN(LAYER_EN), .PIX_DOT(PIX_DOT), .PIX_PAL(PIX_PAL),
    .PIX_OPAQUE(PIX_OPAQUE)
  );

  always #20 clk_24M = ~clk_24M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One pixel slot: strobe, check, then three idle cycles with hostile inputs and PIX_EN low.
  task automatic pe(input logic ld, input logic [31:0] rom, input logic [7:0] col, input logic fl,
                    input logic le, input logic [3:0] ed, input logic [3:0] ep, input string tag);
    @(negedge clk_24M);
    LOAD = ld; ROM_D = rom; COL = col; FLIP = fl; ZH = zh_v; LAYER_EN = le; PIX_EN = 1'b1;
    @(posedge clk_24M);
    #1;
    chk({tag, "_dot"}, 32'(PIX_DOT), 32'(ed));
    chk({tag, "_pal"}, 32'(PIX_PAL), 32'(ep));
    chk({tag, "_opq"}, 32'(PIX_OPAQUE), 32'(ed != 4'h0));
    PIX_EN = 1'b0; LOAD = 1'b1; ROM_D = '1; COL = '1; FLIP = 1'b1; ZH = ~zh_v; LAYER_EN = 1'b0;
    repeat (3) @(posedge clk_24M);
    #1;
    chk({tag, "_hold"}, {24'h0, PIX_PAL, PIX_DOT}, {24'h0, ep, ed});
  endtask

  // Eight slots; expected pixel n is nibble n of ed/ep; the last slot optionally loads the next row.
  task automatic run8(input logic nld, input logic [31:0] nrom, input logic [7:0] ncol, input logic nfl,
                      input logic [7:0] lm, input logic [31:0] ed, input logic [31:0] ep, input string tag);
    for (int n = 0; n < 8; n++)
      pe(nld && n == 7, n == 7 ? nrom : 32'h0, n == 7 ? ncol : 8'h0, nfl, lm[n],
         ed[4*n +: 4], ep[4*n +: 4], $sformatf("%s%0d", tag, n));
  endtask

  initial begin
    nRES = 1'b0; PIX_EN = 1'b0; LOAD = 1'b0; ROM_D = '0; COL = '0; FLIP = 1'b0; ZH = '0;
    LAYER_EN = 1'b1; zh_v = 3'd0;
    #1;
    chk("rst_dot", 32'(PIX_DOT), 0);
    chk("rst_pal", 32'(PIX_PAL), 0);
    chk("rst_opq", 32'(PIX_OPAQUE), 0);
    repeat (2) @(negedge clk_24M);
    nRES = 1'b1;
    pe(1'b1, 32'h87654321, 8'hA0, 1'b0, 1'b1, 4'h0, 4'h0, "e0");
    run8(1'b1, 32'h87654321, 8'hA1, 1'b0, 8'hFF, 32'h0, 32'h0, "pre");
    run8(1'b1, 32'h87654321, 8'hA1, 1'b1, 8'hFF, 32'h87654321, 32'hAAAAAAAA, "order");
    run8(1'b1, 32'hF0F0F0F0, 8'hF0, 1'b0, 8'hFF, 32'h12345678, 32'hAAAAAAAA, "hflip");
    run8(1'b0, 32'h0, 8'h0, 1'b0, 8'hFF, 32'h87654321, 32'hAAAAAAAA, "flip2");
    run8(1'b1, 32'h87654321, 8'hC0, 1'b0, 8'hFF, 32'hF0F0F0F0, 32'hFFFFFFFF, "dot0");
    run8(1'b1, 32'h11111111, 8'h10, 1'b0, 8'hFF, 32'h0, 32'h0, "missed");
    run8(1'b1, 32'h22222222, 8'h20, 1'b0, 8'b1100_0011, 32'h87000021, 32'hCC0000CC, "layer");
    zh_v = 3'd3;
    run8(1'b1, 32'h0, 8'h0, 1'b0, 8'hFF, 32'h22211111, 32'h22211111, "zh3a");
    run8(1'b1, 32'h87654321, 8'h30, 1'b0, 8'hFF, 32'h00022222, 32'h00022222, "zh3b");
    zh_v = 3'd7;
    run8(1'b1, 32'h0, 8'h0, 1'b0, 8'hFF, 32'h76543210, 32'h33333330, "zh7a");
    pe(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 4'h8, 4'h3, "zh7b");
    pe(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 4'h0, 4'h0, "zh7c");
    zh_v = 3'd0;
    pe(1'b1, 32'h87654321, 8'hB0, 1'b0, 1'b1, 4'h3, 4'h3, "resync0");
    run8(1'b1, 32'h0, 8'h0, 1'b0, 8'hFF, 32'h0, 32'h0, "resync");
    for (int n = 1; n <= 4; n++)
      pe(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 4'(n), 4'hB, $sformatf("resync_b%0d", n));
    @(negedge clk_24M);
    #5 nRES = 1'b0;
    #1;
    chk("mrst_dot", 32'(PIX_DOT), 0);
    chk("mrst_pal", 32'(PIX_PAL), 0);
    chk("mrst_opq", 32'(PIX_OPAQUE), 0);
    @(negedge clk_24M);
    nRES = 1'b1;
    pe(1'b1, 32'h87654321, 8'hD0, 1'b0, 1'b1, 4'h0, 4'h0, "post0");
    run8(1'b1, 32'h0, 8'h0, 1'b0, 8'hFF, 32'h0, 32'h0, "post");
    run8(1'b0, 32'h0, 8'h0, 1'b0, 8'hFF, 32'h87654321, 32'hDDDDDDDD, "post2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
